// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer that turns FFT pipeline output into natural order
// (bit-reverse addressing on write) or passes frames through in arrival order.
module fft_reorder #(
   parameter int N = 3,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   input  logic         in_start,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   input  logic         mode,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         out_start,
   output logic         out_last,
   output logic         overflow
);

   localparam int LEN = 1 << N;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DROP
   } wr_state_t;

   wr_state_t      state, state_next;
   logic [1:0]     full;
   logic           wb, rb;
   logic [N-1:0]   wcnt, rcnt;
   logic           mode_lat;
   logic [2*W-1:0] bank [2][LEN];
   logic [2*W-1:0] rd_word;

   logic           read_fire, read_done;
   logic           bank_free, start_seen;
   logic           wr_en, wr_done, wr_mode;
   logic [N-1:0]   wr_idx, wr_addr;

   function automatic logic [N-1:0] bitrev(input logic [N-1:0] x);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
         r[i] = x[N-1-i];
      end
      return r;
   endfunction

   // Read side: the bank under rb streams sequentially whenever it is full.
   assign out_valid = full[rb];
   assign read_fire = out_valid && out_ready;
   assign read_done = read_fire && (rcnt == '1);
   assign rd_word   = bank[rb][rcnt];
   assign out_re    = out_valid ? rd_word[2*W-1:W] : '0;
   assign out_im    = out_valid ? rd_word[W-1:0]   : '0;
   assign out_start = out_valid && (rcnt == '0);
   assign out_last  = out_valid && (rcnt == '1);

   // A full bank draining its last sample this cycle can take a new frame start.
   assign bank_free  = !full[wb] || (read_done && (rb == wb));
   assign start_seen = in_valid && in_start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DROP: begin
            if (start_seen) begin
               state_next = bank_free ? FILL : DROP;
            end
         end
         FILL: begin
            if (in_valid && !in_start && (wcnt == '1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      wr_en    = 1'b0;
      wr_done  = 1'b0;
      wr_idx   = wcnt;
      wr_mode  = mode_lat;
      overflow = 1'b0;
      case (state)
         IDLE, DROP: begin
            if (start_seen) begin
               if (bank_free) begin
                  wr_en   = 1'b1;
                  wr_idx  = '0;
                  wr_mode = mode;
               end else begin
                  overflow = 1'b1;
               end
            end
         end
         FILL: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (in_start) begin
                  wr_idx  = '0;
                  wr_mode = mode;
               end else begin
                  wr_done = (wcnt == '1);
               end
            end
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
      wr_addr = wr_mode ? wr_idx : bitrev(wr_idx);
   end

   // Counters and pointers; a final write and a final read never target the same bank.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full     <= '0;
         wb       <= 1'b0;
         rb       <= 1'b0;
         wcnt     <= '0;
         rcnt     <= '0;
         mode_lat <= 1'b0;
      end else begin
         if (wr_en) begin
            wcnt <= wr_idx + N'(1);
         end
         if (wr_en && in_start) begin
            mode_lat <= mode;
         end
         if (wr_done) begin
            full[wb] <= 1'b1;
            wb       <= ~wb;
         end
         if (read_fire) begin
            rcnt <= rcnt + N'(1);
         end
         if (read_done) begin
            full[rb] <= 1'b0;
            rb       <= ~rb;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         bank[wb][wr_addr] <= {in_re, in_im};
      end
   end

endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter N, default 3: log2 of frame length; frame = 2^N complex samples; legal range 1..10.
REQ-002 Parameter W, default 16: width in bits of each real and imaginary component.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset; asynchronous and active-low.
REQ-005 in_valid  input  1  in_re/in_im carry a sample this cycle.
REQ-006 in_start  input  1  qualified by in_valid; marks sample index 0 of a frame.
REQ-007 in_re, in_im  input  W each  complex input sample, natural FFT-pipeline order.
REQ-008 mode  input  1  0 = bit-reverse reorder, 1 = bypass (natural order); sampled with in_start.
REQ-009 out_ready  input  1  downstream accepts the sample on out_valid && out_ready.
REQ-010 out_valid  output  1  out_re/out_im/out_start/out_last are valid.
REQ-011 out_re, out_im  output  W each  reordered sample.
REQ-012 out_start, out_last  output  1 each  high with output index 0 and index 2^N-1 respectively.
REQ-013 overflow  output  1  one-cycle pulse when an incoming frame is dropped.

Function
REQ-014 Two banks (ping-pong), each 2^N x 2W bits; each bank has a full flag; write-bank pointer wb and read-bank pointer rb, each 1 bit.
REQ-015 Write side states: IDLE (no frame active), FILL (frame active), DROP (discarding frame).
REQ-016 IDLE: in_valid without in_start is ignored; in_valid && in_start -> FILL if bank wb is empty or is freed this same cycle (REQ-024), else -> DROP and overflow=1 for that cycle.
REQ-017 The accepted start sample is written at write index 0; write counter wcnt then increments by one per in_valid sample.
REQ-018 Write address = bitrev_N(wcnt) when latched mode=0, wcnt when latched mode=1; mode is latched only on an accepted in_start.
REQ-019 On the write of index 2^N-1: set full[wb], toggle wb, return to IDLE; no backpressure on the input.
REQ-020 in_valid && in_start while in FILL: discard the partial frame and restart at index 0 in the same bank; mode re-latched; no overflow.
REQ-021 DROP: all samples ignored until in_valid && in_start, which is evaluated exactly as in IDLE.
REQ-022 Read side: out_valid = full[rb]; output data = bank rb at read counter rcnt (sequential 0..2^N-1); out_start = out_valid && rcnt==0; out_last = out_valid && rcnt==2^N-1.
REQ-023 Latency: out_valid rises the cycle after the edge that writes index 2^N-1, provided bank rb was that bank; otherwise as soon as the earlier bank is drained.
REQ-024 rcnt advances only on out_valid && out_ready; on the handshake of index 2^N-1: clear full[rb], toggle rb, rcnt=0.
REQ-025 While out_valid && !out_ready, all outputs hold stable.
REQ-026 Frames leave in arrival order; at most two complete frames are buffered.
REQ-027 Same-cycle final write into bank X and final read of bank X cannot occur; same-cycle final write of one bank and final read of the other both take effect.

Reset
REQ-028 reset_n low asynchronously: full flags=0, wb=rb=0, wcnt=rcnt=0, write state IDLE, latched mode=0.
REQ-029 During reset all outputs = 0 (out_valid, out_start, out_last, overflow, out_re, out_im); bank contents need not be cleared.
REQ-030 Reset asserted mid-frame or mid-output discards all buffered and partial frames; the first frame after release requires in_start.

Verification
REQ-031 N=3, mode=0, out_ready=1, frame samples re=0..7 contiguous -> out_re 0,4,2,6,1,5,3,7, out_valid rising one cycle after sample 7, start on 0, last on 7.
REQ-032 N=3, mode=1, same frame -> out_re 0..7 in order; then mode=0 on the next frame -> bit-reversed order, confirming per-frame latching.
REQ-033 out_ready=0 while three back-to-back frames arrive -> frames 1 and 2 buffered; frame 3 start gives overflow pulse of one cycle; on out_ready=1, exactly 16 samples emerge, frame 1 then frame 2, and frame 3 is absent.
REQ-034 out_ready toggled 1,0,0,1,... during output -> each sample held stable while out_ready=0, with no loss or duplication.
REQ-035 in_start at write index 5, then a full 8-sample frame -> only the second frame is output; overflow stays 0.
REQ-036 reset_n pulsed low while frame 1 is being read and frame 2 is half written -> all outputs 0 immediately; after release no output until a new in_start-led frame completes.
